buf_ram_1p_arb: RTL and testbench
=================================

Name: buf_ram_1p_arb

Overview:
- Arbiter/sequencer that shares one single-port pixel buffer RAM (256 words × 8 pixels) between one writer and two readers.
- Issues at most one RAM access per cycle and returns read data with a registered valid and a per-reader tag.
- Sits between the reconstruction write path and the prediction/filter read paths, directly in front of the buffer RAM wrapper (ce/we active-high).

Parameters:
- ADDR_W, 8, RAM address width.
- DATA_W, 64, RAM word width (PIXEL_WIDTH*8, PIXEL_WIDTH=8).
- WR_BURST_MAX, 4, max consecutive write grants while a read is pending (1..15).

Ports:
- clk  in  1  clock
- rst  in  1  synchronous reset, active-high
- wr_req  in  1  write request; addr/data held stable until wr_gnt
- wr_addr  in  ADDR_W  write address
- wr_data  in  DATA_W  write data
- wr_gnt  out  1  write accepted this cycle (combinational)
- rd0_req  in  1  reader 0 request; addr held until rd0_gnt
- rd0_addr  in  ADDR_W  reader 0 address
- rd0_gnt  out  1  reader 0 accepted this cycle
- rd0_vld  out  1  reader 0 data valid (registered)
- rd1_req  in  1  reader 1 request
- rd1_addr  in  ADDR_W  reader 1 address
- rd1_gnt  out  1  reader 1 accepted this cycle
- rd1_vld  out  1  reader 1 data valid (registered)
- rd_data  out  DATA_W  read data, shared by both readers, qualified by rd0_vld/rd1_vld
- ram_ce  out  1  RAM chip enable, active-high
- ram_we  out  1  RAM write enable, active-high
- ram_addr  out  ADDR_W  RAM address
- ram_wdata  out  DATA_W  RAM write data
- ram_rdata  in  DATA_W  RAM read data, valid 1 cycle after a read access

Behaviour:
- Clock/reset: one clock clk; rst is synchronous, active-high.
- Reset values:
  - rd0_vld = rd1_vld = 0.
  - Round-robin pointer rr = 0 (reader 0 preferred).
  - Write burst counter wcnt = 0.
  - While rst = 1, all grants and ram_ce are forced 0.
- Grant decision: combinational from the current req inputs and registered state (rr, wcnt). At most one grant per cycle.
  - rd_any = rd0_req | rd1_req.
  - Write wins if wr_req & !(rd_any & wcnt == WR_BURST_MAX).
  - Otherwise a read is granted if rd_any.
    - Both readers requesting: the reader selected by rr wins.
    - One reader requesting: that reader wins.
- RAM drive:
  - Any grant: ram_ce = 1. Write grant: ram_we = 1, ram_addr = wr_addr. Read grant: ram_we = 0, ram_addr = rdN_addr.
  - No grant: ram_ce = 0, ram_we = 0.
  - ram_wdata = wr_data at all times.
- Read latency: rdN_gnt in cycle T → rdN_vld = 1 in T+1 for exactly one cycle, with rd_data = ram_rdata (pass-through, unregistered). rd0_vld and rd1_vld are never high together.
- Throughput:
  - Back-to-back grants are allowed every cycle.
  - A reader holding req high after a grant presents the next request. It may be granted again next cycle, subject to arbitration.
- rr update: on any read grant, rr points to the other reader. It is unchanged on write or idle cycles.
- wcnt update, in priority order:
  - Read granted → 0.
  - Write granted while rd_any → wcnt + 1 (saturates at WR_BURST_MAX).
  - No read pending → 0.
  - Otherwise hold.
- Starvation guarantee:
  - A pending read waits at most WR_BURST_MAX cycles of writes.
  - With both readers pending, any reader is granted within 2*(WR_BURST_MAX+1) cycles.
- Boundaries:
  - Reset asserted the cycle after a read grant: vld is suppressed (reset wins over vld set).
  - A read and a write to the same address in adjacent cycles execute in grant order. A read granted after a write returns the new data.
  - Deasserting req without a grant is allowed. No state changes.
  - Address wrap is the caller's responsibility. Addresses pass through unmodified.

Test Plan:
- Reset, then rd0_req with rd0_addr=8'h10 alone, RAM preloaded 64'hA5 → rd0_gnt in T, rd0_vld=1 and rd_data=64'hA5 in T+1; rd1_vld stays 0.
- wr_req addr=8'h20 data=64'h1234 in T, then rd1_req addr=8'h20 → wr_gnt in T, rd1_gnt in T+1, rd1_vld with rd_data=64'h1234 in T+2.
- rd0_req and rd1_req held high for 6 cycles, no writes → grants alternate rd0, rd1, rd0, ...; vlds alternate one cycle later.
- wr_req held high for 10 cycles with rd0_req high (WR_BURST_MAX=4) → 4 wr_gnt, 1 rd0_gnt, 4 wr_gnt, 1 rd0_gnt; wcnt returns to 0 after each read.
- rd1_gnt in T with rst=1 in T+1 → rd1_vld=0 in T+1 and T+2; rr=0 and no grants during reset.
- All req low → ram_ce=0, ram_we=0, no grants or vld for 5 cycles; rr and wcnt unchanged.

Source files
------------

// File: rtl/buf_ram_1p_arb.sv
// ---------------------------------------------------------------------------
// buf_ram_1p_arb
//
// Shares one single-port pixel buffer RAM between one writer and two readers.
// At most one RAM access is issued per cycle. Writes normally win, but once
// WR_BURST_MAX writes have been granted back-to-back while a read is waiting,
// the waiting read is taken. Two competing readers are served round-robin.
// Read data returns one cycle after the grant, qualified by a per-reader
// registered valid.
//
// Ports
//   clk, rst                 clock, synchronous active-high reset
//   wr_req/addr/data, wr_gnt write port; addr/data held until wr_gnt
//   rd0_req/addr, rd0_gnt    reader 0 request/accept
//   rd0_vld                  reader 0 data valid (one cycle after rd0_gnt)
//   rd1_req/addr, rd1_gnt    reader 1 request/accept
//   rd1_vld                  reader 1 data valid (one cycle after rd1_gnt)
//   rd_data                  shared read data (RAM output passed through)
//   ram_ce/we/addr/wdata     RAM drive, active-high enables
//   ram_rdata                RAM read data, one cycle after a read access
// ---------------------------------------------------------------------------
module buf_ram_1p_arb #(
    parameter int ADDR_W       = 8,
    parameter int DATA_W       = 64,
    parameter int WR_BURST_MAX = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wr_req,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    output logic              wr_gnt,
    input  logic              rd0_req,
    input  logic [ADDR_W-1:0] rd0_addr,
    output logic              rd0_gnt,
    output logic              rd0_vld,
    input  logic              rd1_req,
    input  logic [ADDR_W-1:0] rd1_addr,
    output logic              rd1_gnt,
    output logic              rd1_vld,
    output logic [DATA_W-1:0] rd_data,
    output logic              ram_ce,
    output logic              ram_we,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [DATA_W-1:0] ram_wdata,
    input  logic [DATA_W-1:0] ram_rdata
);

    localparam logic [3:0] BURST_MAX = WR_BURST_MAX[3:0];

    logic       rr;        // 0: reader 0 preferred on a tie, 1: reader 1
    logic [3:0] wcnt;      // writes granted while a read has been waiting
    logic       rd0_vld_q;
    logic       rd1_vld_q;

    logic rd_any;
    logic wr_win;
    logic rd1_pick;

    always_comb begin
        rd_any   = rd0_req | rd1_req;
        wr_win   = wr_req & ~(rd_any & (wcnt == BURST_MAX));
        rd1_pick = rd1_req & (rr | ~rd0_req);

        wr_gnt  = ~rst & wr_win;
        rd0_gnt = ~rst & ~wr_win & rd0_req & ~rd1_pick;
        rd1_gnt = ~rst & ~wr_win & rd1_pick;

        ram_ce    = wr_gnt | rd0_gnt | rd1_gnt;
        ram_we    = wr_gnt;
        ram_wdata = wr_data;
        if (wr_gnt) begin
            ram_addr = wr_addr;
        end else if (rd1_gnt) begin
            ram_addr = rd1_addr;
        end else begin
            ram_addr = rd0_addr;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rd0_vld_q <= 1'b0;
            rd1_vld_q <= 1'b0;
            rr        <= 1'b0;
            wcnt      <= 4'd0;
        end else begin
            rd0_vld_q <= rd0_gnt;
            rd1_vld_q <= rd1_gnt;

            if (rd0_gnt | rd1_gnt) begin
                rr <= rd0_gnt;     // hand preference to the other reader
            end

            if (rd0_gnt | rd1_gnt) begin
                wcnt <= 4'd0;
            end else if (wr_gnt & rd_any) begin
                if (wcnt != BURST_MAX) begin
                    wcnt <= wcnt + 4'd1;
                end
            end else if (~rd_any) begin
                wcnt <= 4'd0;
            end
        end
    end

    // A reset arriving the cycle after a read grant must swallow the valid
    // that was already registered, so the valids are masked by rst.
    assign rd0_vld = rd0_vld_q & ~rst;
    assign rd1_vld = rd1_vld_q & ~rst;
    assign rd_data = ram_rdata;

endmodule

// File: tb/tb_buf_ram_1p_arb.sv
module tb_buf_ram_1p_arb;

    logic        clk;
    logic        rst;
    logic        wr_req;
    logic [7:0]  wr_addr;
    logic [63:0] wr_data;
    logic        wr_gnt;
    logic        rd0_req;
    logic [7:0]  rd0_addr;
    logic        rd0_gnt;
    logic        rd0_vld;
    logic        rd1_req;
    logic [7:0]  rd1_addr;
    logic        rd1_gnt;
    logic        rd1_vld;
    logic [63:0] rd_data;
    logic        ram_ce;
    logic        ram_we;
    logic [7:0]  ram_addr;
    logic [63:0] ram_wdata;
    logic [63:0] ram_rdata;

    logic        preload;
    logic [63:0] mem [256];

    int vectors;
    int errors;

    buf_ram_1p_arb #(.ADDR_W(8), .DATA_W(64), .WR_BURST_MAX(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .wr_req    (wr_req),
        .wr_addr   (wr_addr),
        .wr_data   (wr_data),
        .wr_gnt    (wr_gnt),
        .rd0_req   (rd0_req),
        .rd0_addr  (rd0_addr),
        .rd0_gnt   (rd0_gnt),
        .rd0_vld   (rd0_vld),
        .rd1_req   (rd1_req),
        .rd1_addr  (rd1_addr),
        .rd1_gnt   (rd1_gnt),
        .rd1_vld   (rd1_vld),
        .rd_data   (rd_data),
        .ram_ce    (ram_ce),
        .ram_we    (ram_we),
        .ram_addr  (ram_addr),
        .ram_wdata (ram_wdata),
        .ram_rdata (ram_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural single-port RAM, one-cycle read latency.
    always @(posedge clk) begin
        if (preload) begin
            mem[8'h10] <= 64'hA5;
        end else if (ram_ce) begin
            if (ram_we) mem[ram_addr] <= ram_wdata;
            else        ram_rdata     <= mem[ram_addr];
        end
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Inputs change 1 time unit after the rising edge; checks run at +4.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #3;
    endtask

    initial begin
        vectors  = 0;
        errors   = 0;
        rst      = 1'b1;
        preload  = 1'b1;
        wr_req   = 1'b0;
        wr_addr  = 8'h00;
        wr_data  = 64'h0;
        rd0_req  = 1'b0;
        rd0_addr = 8'h10;
        rd1_req  = 1'b0;
        rd1_addr = 8'h20;

        // Reset: requests present but nothing may be granted.
        tick();
        wr_req  = 1'b1;
        rd0_req = 1'b1;
        rd1_req = 1'b1;
        settle();
        chk("rst_wr_gnt",  {63'd0, wr_gnt},  64'd0);
        chk("rst_rd0_gnt", {63'd0, rd0_gnt}, 64'd0);
        chk("rst_rd1_gnt", {63'd0, rd1_gnt}, 64'd0);
        chk("rst_ram_ce",  {63'd0, ram_ce},  64'd0);
        tick();
        wr_req  = 1'b0;
        rd0_req = 1'b0;
        rd1_req = 1'b0;
        settle();
        chk("rst_rd0_vld", {63'd0, rd0_vld}, 64'd0);
        chk("rst_rd1_vld", {63'd0, rd1_vld}, 64'd0);
        chk("rst_rr",      {63'd0, dut.rr},  64'd0);
        chk("rst_wcnt",    {60'd0, dut.wcnt}, 64'd0);
        tick();
        rst     = 1'b0;
        preload = 1'b0;

        // Single read by reader 0.
        tick();
        rd0_req  = 1'b1;
        rd0_addr = 8'h10;
        settle();
        chk("t1_rd0_gnt",  {63'd0, rd0_gnt}, 64'd1);
        chk("t1_ram_ce",   {63'd0, ram_ce},  64'd1);
        chk("t1_ram_we",   {63'd0, ram_we},  64'd0);
        chk("t1_ram_addr", {56'd0, ram_addr}, 64'h10);
        tick();
        rd0_req = 1'b0;
        settle();
        chk("t1_rd0_vld",  {63'd0, rd0_vld}, 64'd1);
        chk("t1_rd1_vld",  {63'd0, rd1_vld}, 64'd0);
        chk("t1_rd_data",  rd_data,          64'hA5);
        tick();
        settle();
        chk("t1_vld_drop", {63'd0, rd0_vld}, 64'd0);

        // Write then read-after-write from reader 1 (rr is now 1).
        tick();
        wr_req  = 1'b1;
        wr_addr = 8'h20;
        wr_data = 64'h1234;
        settle();
        chk("t2_wr_gnt",    {63'd0, wr_gnt}, 64'd1);
        chk("t2_ram_we",    {63'd0, ram_we}, 64'd1);
        chk("t2_ram_addr",  {56'd0, ram_addr}, 64'h20);
        chk("t2_ram_wdata", ram_wdata,        64'h1234);
        tick();
        wr_req   = 1'b0;
        rd1_req  = 1'b1;
        rd1_addr = 8'h20;
        settle();
        chk("t2_rd1_gnt",  {63'd0, rd1_gnt}, 64'd1);
        chk("t2_ram_we_r", {63'd0, ram_we},  64'd0);
        tick();
        rd1_req = 1'b0;
        settle();
        chk("t2_rd1_vld",  {63'd0, rd1_vld}, 64'd1);
        chk("t2_rd0_vld",  {63'd0, rd0_vld}, 64'd0);
        chk("t2_rd_data",  rd_data,          64'h1234);

        // Both readers held for 6 cycles: rr is 0, so rd0,rd1,rd0,...
        tick();
        rd0_req = 1'b1;
        rd1_req = 1'b1;
        for (int i = 0; i < 6; i++) begin
            settle();
            chk($sformatf("t3_rd0_gnt_%0d", i), {63'd0, rd0_gnt}, (i % 2 == 0) ? 64'd1 : 64'd0);
            chk($sformatf("t3_rd1_gnt_%0d", i), {63'd0, rd1_gnt}, (i % 2 == 1) ? 64'd1 : 64'd0);
            if (i > 0) begin
                chk($sformatf("t3_rd0_vld_%0d", i), {63'd0, rd0_vld}, (i % 2 == 1) ? 64'd1 : 64'd0);
                chk($sformatf("t3_rd1_vld_%0d", i), {63'd0, rd1_vld}, (i % 2 == 0) ? 64'd1 : 64'd0);
                chk($sformatf("t3_data_%0d", i), rd_data, (i % 2 == 1) ? 64'hA5 : 64'h1234);
            end
            tick();
        end
        rd0_req = 1'b0;
        rd1_req = 1'b0;
        settle();
        chk("t3_last_rd1_vld", {63'd0, rd1_vld}, 64'd1);
        chk("t3_rr",           {63'd0, dut.rr},  64'd0);

        // Write burst against a pending reader 0: 4 writes, 1 read, repeat.
        tick();
        wr_req   = 1'b1;
        wr_addr  = 8'h30;
        rd0_req  = 1'b1;
        rd0_addr = 8'h10;
        for (int i = 0; i < 10; i++) begin
            wr_data = 64'h100 + 64'(i);
            settle();
            chk($sformatf("t4_wcnt_%0d", i),    {60'd0, dut.wcnt}, 64'(i % 5));
            chk($sformatf("t4_wr_gnt_%0d", i),  {63'd0, wr_gnt},  (i % 5 == 4) ? 64'd0 : 64'd1);
            chk($sformatf("t4_rd0_gnt_%0d", i), {63'd0, rd0_gnt}, (i % 5 == 4) ? 64'd1 : 64'd0);
            if (i == 5) chk("t4_rd0_vld", {63'd0, rd0_vld}, 64'd1);
            tick();
        end
        wr_req  = 1'b0;
        rd0_req = 1'b0;
        settle();
        chk("t4_wcnt_end", {60'd0, dut.wcnt}, 64'd0);
        chk("t4_rr_end",   {63'd0, dut.rr},   64'd1);
        chk("t4_vld_end",  {63'd0, rd0_vld},  64'd1);
        chk("t4_data_end", rd_data,           64'hA5);

        // Reset the cycle after a reader 1 grant swallows the valid.
        tick();
        rd1_req  = 1'b1;
        rd1_addr = 8'h20;
        settle();
        chk("t5_rd1_gnt", {63'd0, rd1_gnt}, 64'd1);
        tick();
        rst = 1'b1;
        settle();
        chk("t5_vld_t1",  {63'd0, rd1_vld}, 64'd0);
        chk("t5_gnt_t1",  {63'd0, rd1_gnt}, 64'd0);
        chk("t5_ce_t1",   {63'd0, ram_ce},  64'd0);
        tick();
        settle();
        chk("t5_vld_t2",  {63'd0, rd1_vld}, 64'd0);
        chk("t5_rr",      {63'd0, dut.rr},  64'd0);
        chk("t5_gnt_t2",  {63'd0, rd1_gnt}, 64'd0);
        tick();
        rst     = 1'b0;
        rd1_req = 1'b0;

        // Idle: one rd0 grant moves rr to 1, then 5 quiet cycles.
        tick();
        rd0_req = 1'b1;
        tick();
        rd0_req = 1'b0;
        tick();
        for (int i = 0; i < 5; i++) begin
            settle();
            chk($sformatf("t6_ce_%0d", i),  {63'd0, ram_ce}, 64'd0);
            chk($sformatf("t6_we_%0d", i),  {63'd0, ram_we}, 64'd0);
            chk($sformatf("t6_gnt_%0d", i), {61'd0, wr_gnt, rd0_gnt, rd1_gnt}, 64'd0);
            chk($sformatf("t6_vld_%0d", i), {62'd0, rd0_vld, rd1_vld}, 64'd0);
            chk($sformatf("t6_rr_%0d", i),  {63'd0, dut.rr}, 64'd1);
            chk($sformatf("t6_wcnt_%0d", i), {60'd0, dut.wcnt}, 64'd0);
            tick();
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
